core_seq_ctrl: RTL and testbench



---
 rtl/core_pkg.sv | 69 ++++++
 rtl/core_seq_ctrl_if.sv | 34 +++
 rtl/pmem_addr_gen.sv | 28 ++
 rtl/core_seq_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_core_seq_ctrl.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// Shared constants, instruction field positions and sequencer state
// encoding for the core instruction sequencer.
package core_pkg;

    // Array / tile geometry
    localparam int ROW      = 8;
    localparam int COL      = 8;
    localparam int LEN_NIJ  = 36;
    localparam int LEN_ONIJ = 16;
    localparam int LEN_KIJ  = 9;
    localparam int GAP_CYC  = 11;

    // Counter and bus widths
    localparam int ADDR_W = 11;
    localparam int CYC_W  = 7;
    localparam int KIJ_W  = 4;
    localparam int ONIJ_W = 4;
    localparam int INST_W = 35;

    // xmem base addresses
    localparam logic [ADDR_W-1:0] W_BASE = 11'h400;
    localparam logic [ADDR_W-1:0] A_BASE = 11'h000;

    // inst bit positions (address fields give their LSB)
    localparam int INST_BYPASS   = 34;
    localparam int INST_ACC      = 33;
    localparam int INST_CEN_PMEM = 32;
    localparam int INST_WEN_PMEM = 31;
    localparam int INST_A_PMEM   = 20;
    localparam int INST_CEN_XMEM = 19;
    localparam int INST_WEN_XMEM = 18;
    localparam int INST_A_XMEM   = 7;
    localparam int INST_OFIFO_RD = 6;
    localparam int INST_IFIFO_WR = 5;
    localparam int INST_IFIFO_RD = 4;
    localparam int INST_L0_RD    = 3;
    localparam int INST_L0_WR    = 2;
    localparam int INST_EXECUTE  = 1;
    localparam int INST_LOAD     = 0;

    // All memory enables deasserted, every strobe low
    localparam logic [INST_W-1:0] INST_IDLE = 35'h1_800C_0000;

    typedef enum logic [3:0] {
        S_IDLE,
        S_W_L0,
        S_K_LOAD,
        S_GAP,
        S_A_L0,
        S_EXEC,
        S_DRAIN,
        S_ACC,
        S_ACC_END,
        S_DONE
    } seq_state_e;

    // xmem -> L0 streaming address: climbs from base, then holds on the
    // last vector while the final L0 write completes.
    function automatic logic [ADDR_W-1:0] ramp_addr(
        input logic [ADDR_W-1:0] base,
        input logic [CYC_W-1:0]  cyc,
        input logic [CYC_W-1:0]  last
    );
        logic [CYC_W-1:0] step;
        step = (cyc > last) ? last : cyc;
        return base + ADDR_W'(step);
    endfunction

endpackage

// File: rtl/core_seq_ctrl_if.sv
// Handshake/status bundle between the host side and the sequencer.
// master: drives start/ofifo_valid; slave: drives inst and status.
interface core_seq_ctrl_if;
    import core_pkg::*;

    logic              start;
    logic              ofifo_valid;
    logic [INST_W-1:0] inst;
    logic              busy;
    logic              done;
    logic              out_valid;
    logic [ONIJ_W-1:0] onij_idx;

    modport master (
        output start,
        output ofifo_valid,
        input  inst,
        input  busy,
        input  done,
        input  out_valid,
        input  onij_idx
    );

    modport slave (
        input  start,
        input  ofifo_valid,
        output inst,
        output busy,
        output done,
        output out_valid,
        output onij_idx
    );

endinterface

// File: rtl/pmem_addr_gen.sv
// Combinational pmem address: block*LEN_ONIJ + offset.
// Ports: acc_mode selects ACC (block=j from cyc, offset=onij) vs DRAIN
// (block=kij, offset=cnt from cyc); addr is the 11-bit A_pmem value.
module pmem_addr_gen
    import core_pkg::*;
(
    input  logic              acc_mode,
    input  logic [KIJ_W-1:0]  kij,
    input  logic [ONIJ_W-1:0] onij,
    input  logic [3:0]        cnt,
    output logic [ADDR_W-1:0] addr
);

    logic [3:0] blk;
    logic [3:0] ofs;

    always_comb begin
        blk = kij;
        ofs = cnt;
        if (acc_mode) begin
            blk = cnt;
            ofs = onij;
        end
    end

    assign addr = ADDR_W'(blk) * ADDR_W'(LEN_ONIJ) + ADDR_W'(ofs);

endmodule

// File: rtl/core_seq_ctrl.sv
// Tile sequencer for core: emits one registered 35-bit inst per cycle.
// Ports: clk, reset (async active-low), bus (slave side of the bundle).
module core_seq_ctrl
    import core_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    core_seq_ctrl_if.slave bus
);

    localparam logic [CYC_W-1:0] C_COL     = CYC_W'(COL);
    localparam logic [CYC_W-1:0] C_COL_M1  = CYC_W'(COL - 1);
    localparam logic [CYC_W-1:0] C_ROW     = CYC_W'(ROW);
    localparam logic [CYC_W-1:0] C_KL_LAST = CYC_W'(ROW + COL - 1);
    localparam logic [CYC_W-1:0] C_GP_LAST = CYC_W'(GAP_CYC - 1);
    localparam logic [CYC_W-1:0] C_NIJ     = CYC_W'(LEN_NIJ);
    localparam logic [CYC_W-1:0] C_NIJ_M1  = CYC_W'(LEN_NIJ - 1);
    localparam logic [CYC_W-1:0] C_EX_LAST = CYC_W'(ROW + COL + LEN_NIJ - 1);
    localparam logic [CYC_W-1:0] C_DR_LAST = CYC_W'(LEN_ONIJ - 1);
    localparam logic [CYC_W-1:0] C_AC_LAST = CYC_W'(LEN_KIJ - 1);
    localparam logic [CYC_W-1:0] C_AE_LAST = CYC_W'(2);

    localparam logic [KIJ_W-1:0]  KIJ_LAST  = KIJ_W'(LEN_KIJ - 1);
    localparam logic [ONIJ_W-1:0] ONIJ_LAST = ONIJ_W'(LEN_ONIJ - 1);

    seq_state_e        state_q, state_d;
    logic [CYC_W-1:0]  cyc_q, cyc_d;
    logic [KIJ_W-1:0]  kij_q, kij_d;
    logic [ONIJ_W-1:0] onij_q, onij_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic              out_valid_q, out_valid_d;
    logic [ONIJ_W-1:0] onij_idx_q, onij_idx_d;

    logic [ADDR_W-1:0] pmem_addr;

    pmem_addr_gen u_pmem_addr_gen (
        .acc_mode (state_q == S_ACC),
        .kij      (kij_q),
        .onij     (onij_q),
        .cnt      (cyc_q[3:0]),
        .addr     (pmem_addr)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cyc_q       <= '0;
            kij_q       <= '0;
            onij_q      <= '0;
            inst_q      <= INST_IDLE;
            out_valid_q <= 1'b0;
            onij_idx_q  <= '0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            kij_q       <= kij_d;
            onij_q      <= onij_d;
            inst_q      <= inst_d;
            out_valid_q <= out_valid_d;
            onij_idx_q  <= onij_idx_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        kij_d       = kij_q;
        onij_d      = onij_q;
        inst_d      = INST_IDLE;
        out_valid_d = 1'b0;
        onij_idx_d  = onij_idx_q;

        inst_d[INST_IFIFO_WR] = 1'b0;
        inst_d[INST_IFIFO_RD] = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_W_L0;
                    cyc_d   = '0;
                    kij_d   = '0;
                    onij_d  = '0;
                end
            end

            S_W_L0: begin
                inst_d[INST_CEN_XMEM] = 1'b0;
                inst_d[INST_A_XMEM +: ADDR_W] =
                    ramp_addr(W_BASE, cyc_q, C_COL_M1);
                // first cycle only issues the xmem read
                inst_d[INST_L0_WR] = (cyc_q != '0);
                if (cyc_q == C_COL) begin
                    state_d = S_K_LOAD;
                    cyc_d   = '0;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end

            S_K_LOAD: begin
                inst_d[INST_LOAD]  = 1'b1;
                inst_d[INST_L0_RD] = (cyc_q < C_ROW);
                if (cyc_q == C_KL_LAST) begin
                    state_d = S_GAP;
                    cyc_d   = '0;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end

            S_GAP: begin
                if (cyc_q == C_GP_LAST) begin
                    state_d = S_A_L0;
                    cyc_d   = '0;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end

            S_A_L0: begin
                inst_d[INST_CEN_XMEM] = (cyc_q == C_NIJ);
                inst_d[INST_A_XMEM +: ADDR_W] =
                    ramp_addr(A_BASE, cyc_q, C_NIJ_M1);
                inst_d[INST_L0_WR] = (cyc_q != '0);
                if (cyc_q == C_NIJ) begin
                    state_d = S_EXEC;
                    cyc_d   = '0;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end

            S_EXEC: begin
                inst_d[INST_EXECUTE] = 1'b1;
                inst_d[INST_L0_RD]   = 1'b1;
                if (cyc_q == C_EX_LAST) begin
                    state_d = S_DRAIN;
                    cyc_d   = '0;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end

            S_DRAIN: begin
                inst_d[INST_BYPASS] = 1'b1;
                // cyc_q counts completed pmem writes for this kij
                if (bus.ofifo_valid) begin
                    inst_d[INST_OFIFO_RD]           = 1'b1;
                    inst_d[INST_CEN_PMEM]           = 1'b0;
                    inst_d[INST_WEN_PMEM]           = 1'b0;
                    inst_d[INST_A_PMEM +: ADDR_W]   = pmem_addr;
                    if (cyc_q == C_DR_LAST) begin
                        cyc_d = '0;
                        if (kij_q == KIJ_LAST) begin
                            state_d = S_ACC;
                            onij_d  = '0;
                        end else begin
                            state_d = S_W_L0;
                            kij_d   = kij_q + 1'b1;
                        end
                    end else begin
                        cyc_d = cyc_q + 1'b1;
                    end
                end
            end

            S_ACC: begin
                // cyc_q walks the kij partial sums of pixel onij_q
                inst_d[INST_ACC]              = 1'b1;
                inst_d[INST_CEN_PMEM]         = 1'b0;
                inst_d[INST_A_PMEM +: ADDR_W] = pmem_addr;
                if (cyc_q == C_AC_LAST) begin
                    state_d = S_ACC_END;
                    cyc_d   = '0;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end

            S_ACC_END: begin
                // idle word drops acc, letting the SFU apply ReLU and flush
                if (cyc_q == C_AE_LAST) begin
                    out_valid_d = 1'b1;
                    onij_idx_d  = onij_q;
                    cyc_d       = '0;
                    if (onij_q == ONIJ_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ACC;
                        onij_d  = onij_q + 1'b1;
                    end
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.inst      = inst_q;
    assign bus.busy      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign bus.done      = (state_q == S_DONE);
    assign bus.out_valid = out_valid_q;
    assign bus.onij_idx  = onij_idx_q;

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Bench for core_seq_ctrl: expected inst stream built from the field map
// and tile schedule, compared cycle by cycle under random ofifo_valid.
module tb_core_seq_ctrl;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    core_seq_ctrl_if ifc ();

    core_seq_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [34:0] exp_q[$];
    bit          vld_q[$];
    bit          drn_q[$];
    bit          ov_q[$];
    logic [3:0]  oi_q[$];

    localparam logic [34:0] IDLE_LIT = 35'h1_800C_0000;

    task automatic chk(input string tag, input logic [34:0] obs,
                       input logic [34:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [34:0] mk(
        input bit byp, input bit acc, input bit cenp, input bit wenp,
        input int ap, input bit cenx, input bit wenx, input int ax,
        input bit ofr, input bit l0r, input bit l0w, input bit ex,
        input bit ld
    );
        logic [10:0] a_p;
        logic [10:0] a_x;
        a_p = 11'(ap);
        a_x = 11'(ax);
        return {byp, acc, cenp, wenp, a_p, cenx, wenx, a_x,
                ofr, 1'b0, 1'b0, l0r, l0w, ex, ld};
    endfunction

    function automatic logic [34:0] idle_w();
        return mk(0, 0, 1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    endfunction

    task automatic push(input logic [34:0] w, input bit v, input bit d,
                        input bit ov, input int oi);
        exp_q.push_back(w);
        vld_q.push_back(v);
        drn_q.push_back(d);
        ov_q.push_back(ov);
        oi_q.push_back(4'(oi));
    endtask

    function automatic bit rbit();
        return bit'($urandom_range(1));
    endfunction

    // Expected word i appears at core after the (i+1)-th edge past start;
    // vld_q[i] is the ofifo_valid the sequencer sees when deciding word i.
    task automatic build_tile(input int pct);
        bit v;
        int n;
        exp_q.delete();
        vld_q.delete();
        drn_q.delete();
        ov_q.delete();
        oi_q.delete();
        for (int k = 0; k < 9; k++) begin
            for (int c = 0; c <= 8; c++)
                push(mk(0, 0, 1, 1, 0, 0, 1, 'h400 + (c < 8 ? c : 7),
                        0, 0, c != 0, 0, 0), rbit(), 0, 0, 0);
            for (int c = 0; c < 16; c++)
                push(mk(0, 0, 1, 1, 0, 1, 1, 0, 0, c < 8, 0, 0, 1),
                     rbit(), 0, 0, 0);
            for (int c = 0; c < 11; c++)
                push(idle_w(), rbit(), 0, 0, 0);
            for (int c = 0; c <= 36; c++)
                push(mk(0, 0, 1, 1, 0, c == 36, 1, (c < 36 ? c : 35),
                        0, 0, c != 0, 0, 0), rbit(), 0, 0, 0);
            for (int c = 0; c < 52; c++)
                push(mk(0, 0, 1, 1, 0, 1, 1, 0, 0, 1, 0, 1, 0),
                     rbit(), 0, 0, 0);
            n = 0;
            while (n < 16) begin
                v = ($urandom_range(99) < pct);
                if (v) begin
                    push(mk(1, 0, 0, 0, k * 16 + n, 1, 1, 0, 1, 0, 0, 0, 0),
                         1, 1, 0, 0);
                    n++;
                end else begin
                    push(mk(1, 0, 1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0),
                         0, 1, 0, 0);
                end
            end
        end
        for (int o = 0; o < 16; o++) begin
            for (int j = 0; j < 9; j++)
                push(mk(0, 1, 0, 1, j * 16 + o, 1, 1, 0, 0, 0, 0, 0, 0),
                     rbit(), 0, 0, 0);
            push(idle_w(), rbit(), 0, 0, 0);
            push(idle_w(), rbit(), 0, 0, 0);
            push(idle_w(), rbit(), 0, 1, o);
        end
        push(idle_w(), 0, 0, 0, 0);
    endtask

    task automatic run_tile(input int pct, input int stop_at);
        int last;
        int n_ov;
        int n_done;
        build_tile(pct);
        last = exp_q.size() - 1;
        n_ov = 0;
        n_done = 0;
        ifc.start       = 1'b1;
        ifc.ofifo_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("start_inst", ifc.inst, IDLE_LIT);
        chk("start_busy", 35'(ifc.busy), 35'd1);
        ifc.start       = 1'b0;
        ifc.ofifo_valid = vld_q[0];
        for (int i = 0; i <= last; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("inst[%0d]", i), ifc.inst, exp_q[i]);
            chk($sformatf("ov[%0d]", i), 35'(ifc.out_valid), 35'(ov_q[i]));
            if (ov_q[i])
                chk($sformatf("oidx[%0d]", i), 35'(ifc.onij_idx),
                    35'(oi_q[i]));
            chk($sformatf("done[%0d]", i), 35'(ifc.done),
                35'(i == last - 1));
            chk($sformatf("busy[%0d]", i), 35'(ifc.busy),
                35'(i < last - 1));
            n_ov   += int'(ifc.out_valid);
            n_done += int'(ifc.done);
            if (i == stop_at)
                return;
            if (i < last) begin
                ifc.ofifo_valid = vld_q[i + 1];
                // start pulses while draining must be ignored
                ifc.start = drn_q[i + 1] && ($urandom_range(3) == 0);
            end
        end
        ifc.start = 1'b0;
        chk("ov_count", 35'(n_ov), 35'd16);
        chk("done_count", 35'(n_done), 35'd1);
    endtask

    initial begin
        total           = 0;
        bad             = 0;
        reset           = 1'b0;
        ifc.start       = 1'b0;
        ifc.ofifo_valid = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_inst", ifc.inst, IDLE_LIT);
        chk("rst_busy", 35'(ifc.busy), 35'd0);
        chk("rst_done", 35'(ifc.done), 35'd0);
        chk("rst_ov", 35'(ifc.out_valid), 35'd0);
        chk("rst_oidx", 35'(ifc.onij_idx), 35'd0);
        reset = 1'b1;

        repeat (4) begin
            @(posedge clk);
            #1;
            ifc.ofifo_valid = rbit();
            chk("pre_idle", ifc.inst, IDLE_LIT);
        end
        ifc.ofifo_valid = 1'b0;

        // abort in the middle of kij 0 EXEC
        run_tile(50, 83);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_inst", ifc.inst, IDLE_LIT);
        chk("mid_rst_busy", 35'(ifc.busy), 35'd0);
        chk("mid_rst_ov", 35'(ifc.out_valid), 35'd0);
        ifc.start       = 1'b0;
        ifc.ofifo_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            ifc.ofifo_valid = rbit();
            chk("post_rst_inst", ifc.inst, IDLE_LIT);
            chk("post_rst_busy", 35'(ifc.busy), 35'd0);
        end
        ifc.ofifo_valid = 1'b0;

        run_tile(50, -1);
        repeat (3) @(posedge clk);
        #1;
        chk("between_inst", ifc.inst, IDLE_LIT);
        run_tile(95, -1);
        repeat (2) @(posedge clk);
        #1;
        chk("end_inst", ifc.inst, IDLE_LIT);
        chk("end_busy", 35'(ifc.busy), 35'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
